usb_reg_frontend: RTL and testbench

//  Converts the CW305 SAM3U parallel bus (addr/data, cen_n/rd_n/wr_n) into the

---
 rtl/usb_reg_frontend_pkg.sv | 13 +
 rtl/usb_strobe_edge.sv | 40 ++++
 rtl/usb_reg_frontend.sv | 133 +++++++++++++
 tb/tb_usb_reg_frontend.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_reg_frontend_pkg.sv
// rtl/usb_reg_frontend_pkg.sv - shared widths and strobe helper for the host bus front end
package usb_reg_frontend_pkg;

  localparam int USB_ADDR_WIDTH   = 21;
  localparam int USB_BYTECNT_SIZE = 7;
  localparam int USB_DATA_WIDTH   = 8;

  // A host strobe counts as newly asserted only while the chip is selected.
  function automatic logic strobe_fell(input logic s1_n, input logic s2_n, input logic cen_n_s1);
    return ~s1_n & s2_n & ~cen_n_s1;
  endfunction

endpackage

// File: rtl/usb_strobe_edge.sv
// rtl/usb_strobe_edge.sv - input synchroniser stages and falling-edge detect for active-low strobes
module usb_strobe_edge
  import usb_reg_frontend_pkg::*;
(
  input  logic usb_clk,
  input  logic reset_n,
  input  logic cen_n,
  input  logic rd_n,
  input  logic wr_n,
  output logic cen_n_s1,
  output logic rd_n_s1,
  output logic wr_n_s1,
  output logic rd_fall,
  output logic wr_fall
);

  logic rd_n_s2;
  logic wr_n_s2;

  // S1/S2 stages; strobes reset to "already low" so a strobe held across reset never looks new.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      cen_n_s1 <= 1'b1;
      rd_n_s1  <= 1'b0;
      wr_n_s1  <= 1'b0;
      rd_n_s2  <= 1'b0;
      wr_n_s2  <= 1'b0;
    end else begin
      cen_n_s1 <= cen_n;
      rd_n_s1  <= rd_n;
      wr_n_s1  <= wr_n;
      rd_n_s2  <= rd_n_s1;
      wr_n_s2  <= wr_n_s1;
    end
  end

  assign rd_fall = strobe_fell(rd_n_s1, rd_n_s2, cen_n_s1);
  assign wr_fall = strobe_fell(wr_n_s1, wr_n_s2, cen_n_s1);

endmodule

// File: rtl/usb_reg_frontend.sv
// rtl/usb_reg_frontend.sv - host parallel bus to register strobe interface
module usb_reg_frontend
  import usb_reg_frontend_pkg::*;
#(
  parameter int pADDR_WIDTH   = USB_ADDR_WIDTH,
  parameter int pBYTECNT_SIZE = USB_BYTECNT_SIZE
) (
  input  logic                               usb_clk,
  input  logic                               reset_n,
  input  logic [pADDR_WIDTH-1:0]             usb_addr,
  input  logic [7:0]                         usb_din,
  output logic [7:0]                         usb_dout,
  output logic                               usb_isout,
  input  logic                               usb_cen_n,
  input  logic                               usb_rd_n,
  input  logic                               usb_wr_n,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]           reg_bytecnt,
  output logic [7:0]                         write_data,
  input  logic [7:0]                         read_data,
  output logic                               reg_read,
  output logic                               reg_write,
  output logic                               reg_addrvalid
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_PULSE = 3'd1,
    RD_PULSE = 3'd2,
    RD_CAPT  = 3'd3,
    RD_HOLD  = 3'd4
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [pADDR_WIDTH-1:0]   usb_addr_s1;
  logic [7:0]               usb_din_s1;
  logic                     cen_n_s1;
  logic                     rd_n_s1;
  logic                     wr_n_s1;
  logic                     rd_fall;
  logic                     wr_fall;

  usb_strobe_edge u_strobe_edge (
    .usb_clk  (usb_clk),
    .reset_n  (reset_n),
    .cen_n    (usb_cen_n),
    .rd_n     (usb_rd_n),
    .wr_n     (usb_wr_n),
    .cen_n_s1 (cen_n_s1),
    .rd_n_s1  (rd_n_s1),
    .wr_n_s1  (wr_n_s1),
    .rd_fall  (rd_fall),
    .wr_fall  (wr_fall)
  );

  // S1 copy of the host address and write data.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      usb_addr_s1 <= '0;
      usb_din_s1  <= '0;
    end else begin
      usb_addr_s1 <= usb_addr;
      usb_din_s1  <= usb_din;
    end
  end

  // State register.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and strobe/enable decode; one strobe per host access, deselect aborts.
  always_comb begin
    state_nxt = state;
    reg_write = 1'b0;
    reg_read  = 1'b0;
    usb_isout = 1'b0;
    case (state)
      IDLE: begin
        if (!(~rd_n_s1 && ~wr_n_s1)) begin
          if (wr_fall)      state_nxt = WR_PULSE;
          else if (rd_fall) state_nxt = RD_PULSE;
        end
      end
      WR_PULSE: begin
        reg_write = 1'b1;
        state_nxt = IDLE;
      end
      RD_PULSE: begin
        reg_read  = 1'b1;
        usb_isout = 1'b1;
        state_nxt = RD_CAPT;
      end
      RD_CAPT: begin
        usb_isout = 1'b1;
        state_nxt = RD_HOLD;
      end
      RD_HOLD: begin
        usb_isout = 1'b1;
        if (rd_n_s1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && cen_n_s1) state_nxt = IDLE;
  end

  // Address/data track S1 while idle and freeze for the duration of an access.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_address <= '0;
      reg_bytecnt <= '0;
      write_data  <= '0;
    end else if (state == IDLE) begin
      reg_address <= usb_addr_s1[pADDR_WIDTH-1:pBYTECNT_SIZE];
      reg_bytecnt <= usb_addr_s1[pBYTECNT_SIZE-1:0];
      write_data  <= usb_din_s1;
    end
  end

  // Read byte captured one cycle after the read pulse; address-valid follows chip select.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      usb_dout      <= '0;
      reg_addrvalid <= 1'b0;
    end else begin
      reg_addrvalid <= ~cen_n_s1;
      if (state == RD_CAPT) usb_dout <= read_data;
    end
  end

endmodule

// File: tb/tb_usb_reg_frontend.sv
// tb/tb_usb_reg_frontend.sv - scoreboard bench for usb_reg_frontend
module tb_usb_reg_frontend;

  localparam logic [13:0] REG_TEST = 14'h0021;

  typedef struct {
    logic [13:0] addr;
    logic [6:0]  bc;
    logic [7:0]  data;
  } xact_t;

  logic        usb_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [20:0] usb_addr = '0;
  logic [7:0]  usb_din = '0;
  logic [7:0]  usb_dout;
  logic        usb_isout;
  logic        usb_cen_n = 1'b1;
  logic        usb_rd_n = 1'b1;
  logic        usb_wr_n = 1'b1;
  logic [13:0] reg_address;
  logic [6:0]  reg_bytecnt;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;

  logic [7:0]  mem [0:127];
  xact_t       wr_q[$];
  xact_t       rd_q[$];
  xact_t       rd_cur;
  int          rd_wait = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_pulses = 0;
  int          rd_pulses = 0;

  usb_reg_frontend dut (
    .usb_clk       (usb_clk),
    .reset_n       (reset_n),
    .usb_addr      (usb_addr),
    .usb_din       (usb_din),
    .usb_dout      (usb_dout),
    .usb_isout     (usb_isout),
    .usb_cen_n     (usb_cen_n),
    .usb_rd_n      (usb_rd_n),
    .usb_wr_n      (usb_wr_n),
    .reg_address   (reg_address),
    .reg_bytecnt   (reg_bytecnt),
    .write_data    (write_data),
    .read_data     (read_data),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .reg_addrvalid (reg_addrvalid)
  );

  always #5 usb_clk = ~usb_clk;

  // Register block model: byte 5 is a fixed 3C, other bytes are plain storage.
  always @(posedge usb_clk) begin
    if (reg_write) mem[reg_bytecnt] <= write_data;
    if (reg_read)  read_data <= (reg_bytecnt == 7'd5) ? 8'h3C : mem[reg_bytecnt];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, checks read data two samples later.
  always @(negedge usb_clk) begin
    if (rd_wait > 0) begin
      rd_wait--;
      if (rd_wait == 0) begin
        check("read_dout", {24'd0, usb_dout}, {24'd0, rd_cur.data});
        check("read_isout", {31'd0, usb_isout}, 32'd1);
      end
    end
    if (reg_write) begin
      wr_pulses++;
      if (wr_q.size() == 0) check("unexpected_write", {31'd0, reg_write}, 32'd0);
      else begin
        xact_t e;
        e = wr_q.pop_front();
        check("write_addr", {18'd0, reg_address}, {18'd0, e.addr});
        check("write_bytecnt", {25'd0, reg_bytecnt}, {25'd0, e.bc});
        check("write_data", {24'd0, write_data}, {24'd0, e.data});
      end
    end
    if (reg_read) begin
      rd_pulses++;
      if (rd_q.size() == 0) check("unexpected_read", {31'd0, reg_read}, 32'd0);
      else begin
        rd_cur = rd_q.pop_front();
        check("read_addr", {18'd0, reg_address}, {18'd0, rd_cur.addr});
        check("read_bytecnt", {25'd0, reg_bytecnt}, {25'd0, rd_cur.bc});
        rd_wait = 2;
      end
    end
  end

  task automatic host_write(input logic [6:0] bc, input logic [7:0] d, input int low);
    wr_q.push_back('{REG_TEST, bc, d});
    usb_addr  = {REG_TEST, bc};
    usb_din   = d;
    usb_cen_n = 1'b0;
    @(negedge usb_clk);
    usb_wr_n = 1'b0;
    repeat (low) @(negedge usb_clk);
    check("write_addrvalid", {31'd0, reg_addrvalid}, 32'd1);
    usb_wr_n = 1'b1;
    @(negedge usb_clk);
    usb_cen_n = 1'b1;
    @(negedge usb_clk);
  endtask

  task automatic host_read(input logic [6:0] bc, input logic [7:0] d, input int low);
    rd_q.push_back('{REG_TEST, bc, d});
    usb_addr  = {REG_TEST, bc};
    usb_cen_n = 1'b0;
    @(negedge usb_clk);
    usb_rd_n = 1'b0;
    repeat (low) @(negedge usb_clk);
    check("read_hold_isout", {31'd0, usb_isout}, 32'd1);
    usb_rd_n = 1'b1;
    repeat (2) @(negedge usb_clk);
    check("read_release_isout", {31'd0, usb_isout}, 32'd0);
    usb_cen_n = 1'b1;
    @(negedge usb_clk);
  endtask

  initial begin
    repeat (3) @(negedge usb_clk);
    check("reset_outputs",
          {usb_dout, usb_isout, reg_read, reg_write, reg_addrvalid, write_data, reg_bytecnt, 1'b0},
          32'd0);
    check("reset_address", {18'd0, reg_address}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge usb_clk);

    // 1) single write
    host_write(7'd2, 8'hA5, 3);
    // 2) read of a fixed 3C register byte
    host_read(7'd5, 8'h3C, 6);
    // 3) back-to-back writes then reads
    host_write(7'd0, 8'h11, 2);
    host_write(7'd1, 8'h22, 2);
    host_write(7'd2, 8'h33, 2);
    host_write(7'd3, 8'h44, 2);
    host_read(7'd0, 8'h11, 5);
    host_read(7'd1, 8'h22, 5);
    host_read(7'd2, 8'h33, 5);
    host_read(7'd3, 8'h44, 5);

    // 4) chip select dropped at N+2 of a read
    rd_q.push_back('{REG_TEST, 7'd1, 8'h22});
    usb_addr  = {REG_TEST, 7'd1};
    usb_cen_n = 1'b0;
    @(negedge usb_clk);
    usb_rd_n = 1'b0;
    repeat (3) @(negedge usb_clk);
    usb_cen_n = 1'b1;
    repeat (2) @(negedge usb_clk);
    check("abort_isout", {31'd0, usb_isout}, 32'd0);
    check("abort_addrvalid", {31'd0, reg_addrvalid}, 32'd0);
    repeat (3) @(negedge usb_clk);
    usb_rd_n = 1'b1;
    repeat (2) @(negedge usb_clk);

    // 5) rd and wr asserted together
    usb_addr  = {REG_TEST, 7'd6};
    usb_cen_n = 1'b0;
    @(negedge usb_clk);
    usb_rd_n = 1'b0;
    usb_wr_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge usb_clk);
      check("both_low_isout", {31'd0, usb_isout}, 32'd0);
    end
    usb_rd_n  = 1'b1;
    usb_wr_n  = 1'b1;
    @(negedge usb_clk);
    usb_cen_n = 1'b1;
    repeat (2) @(negedge usb_clk);

    // 6) reset during RD_HOLD with rd_n held low through release
    rd_q.push_back('{REG_TEST, 7'd3, 8'h44});
    usb_addr  = {REG_TEST, 7'd3};
    usb_cen_n = 1'b0;
    @(negedge usb_clk);
    usb_rd_n = 1'b0;
    repeat (5) @(negedge usb_clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs",
          {usb_dout, usb_isout, reg_read, reg_write, reg_addrvalid, write_data, reg_bytecnt, 1'b0},
          32'd0);
    check("midreset_address", {18'd0, reg_address}, 32'd0);
    @(negedge usb_clk);
    reset_n = 1'b1;
    repeat (5) @(negedge usb_clk);
    check("post_reset_isout", {31'd0, usb_isout}, 32'd0);
    usb_rd_n = 1'b1;
    @(negedge usb_clk);
    usb_cen_n = 1'b1;
    repeat (3) @(negedge usb_clk);

    check("write_pulse_count", wr_pulses, 32'd5);
    check("read_pulse_count", rd_pulses, 32'd7);
    check("write_queue_drained", wr_q.size(), 32'd0);
    check("read_queue_drained", rd_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
